fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq.sv | 127 ++++++++++++
 tb/tb_fir_mac_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Sequencer for a time-multiplexed FIR: a sample-rate divider starts a LOAD/MAC/FLUSH
// walk over N+1 taps. Optional sticky overrun flag: define FIR_MAC_SEQ_OVERRUN_EN.
module fir_mac_seq #(
  parameter int N    = 10,
  parameter int FS   = 58000,
  parameter int FCLK = 50000000,
  localparam int AW  = ((N + 1) > 1) ? $clog2(N + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          sample_tick,
  output logic          x_we,
  output logic [AW-1:0] x_waddr,
  output logic [AW-1:0] x_raddr,
  output logic [AW-1:0] c_raddr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          y_valid,
  output logic          busy,
  output logic          overrun,
  output logic [1:0]    fsm_state
);

  localparam int DIV = FCLK / FS;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [AW-1:0] LAST_TAP = AW'(N);
  localparam logic [AW:0]   TAPS     = (AW + 1)'(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MAC   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wptr_q, base_q, k_q;
  logic [AW:0]   tap_sum;
  logic          tick, in_mac;

  // Sample-rate divider; en low parks the count at zero so restart is aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == DIV_LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign tick        = en && (cnt_q == DIV_LAST);
  assign sample_tick = tick;
  assign busy        = (state_q != S_IDLE) || mac_en;
  assign fsm_state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick && !busy) state_d = S_LOAD;
      S_LOAD:  state_d = S_MAC;
      S_MAC:   if (k_q == LAST_TAP) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Newest sample sits at base; tap k reads (base - k) mod (N+1).
  assign in_mac  = (state_q == S_MAC);
  assign tap_sum = (k_q > base_q) ? ({1'b0, base_q} + TAPS - {1'b0, k_q})
                                  : ({1'b0, base_q} - {1'b0, k_q});

  always_comb begin
    x_we    = (state_q == S_LOAD);
    x_waddr = wptr_q;
    x_raddr = '0;
    c_raddr = '0;
    if (in_mac) begin
      x_raddr = tap_sum[AW-1:0];
      c_raddr = k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      // Accumulator controls trail the address phase by the RAM read latency.
      mac_en  <= in_mac;
      mac_clr <= in_mac && (k_q == '0);
      y_valid <= (state_q == S_FLUSH);
      if (state_q == S_LOAD) begin
        base_q <= wptr_q;
        wptr_q <= (wptr_q == LAST_TAP) ? '0 : wptr_q + 1'b1;
        k_q    <= '0;
      end else if (in_mac && (k_q != LAST_TAP)) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

`ifdef FIR_MAC_SEQ_OVERRUN_EN
  logic drop;
  assign drop = tick && busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: default config (DIV=862) plus a DIV=10 overrun instance.
module tb_fir_mac_seq;

  localparam int NT = 10;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rst_b, en_b;
  logic          sample_tick, x_we, mac_clr, mac_en, y_valid, busy, overrun;
  logic [AW-1:0] x_waddr, x_raddr, c_raddr;
  logic [1:0]    fsm_state;
  logic          tick_b, x_we_b, mac_clr_b, mac_en_b, y_valid_b, busy_b, overrun_b;
  logic [AW-1:0] x_waddr_b, x_raddr_b, c_raddr_b;
  logic [1:0]    fsm_state_b;

  int errors = 0;
  int checks = 0;
  int n;
  int exp_ovr;

  fir_mac_seq #(.N(NT), .FS(58000), .FCLK(50000000)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick), .x_we(x_we),
    .x_waddr(x_waddr), .x_raddr(x_raddr), .c_raddr(c_raddr), .mac_clr(mac_clr),
    .mac_en(mac_en), .y_valid(y_valid), .busy(busy), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  fir_mac_seq #(.N(NT), .FS(58000), .FCLK(580000)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sample_tick(tick_b), .x_we(x_we_b),
    .x_waddr(x_waddr_b), .x_raddr(x_raddr_b), .c_raddr(c_raddr_b), .mac_clr(mac_clr_b),
    .mac_en(mac_en_b), .y_valid(y_valid_b), .busy(busy_b), .overrun(overrun_b),
    .fsm_state(fsm_state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    while (!sample_tick && cnt < 5000) begin
      step();
      cnt++;
    end
  endtask

  // Checks cycles T+1..T+14 after a tick observed in cycle T.
  task automatic run_seq(input int base, input int drop_at);
    for (int i = 1; i <= 14; i++) begin
      int  k;
      logic im;
      step();
      k  = i - 2;
      im = (i >= 2) && (i <= NT + 2);
      chk("x_we", x_we, i == 1);
      if (i == 1) chk("x_waddr", x_waddr, base);
      chk("x_raddr", x_raddr, im ? (base - k + NT + 1) % (NT + 1) : 0);
      chk("c_raddr", c_raddr, im ? k : 0);
      chk("mac_en", mac_en, (i >= 3) && (i <= NT + 3));
      chk("mac_clr", mac_clr, i == 3);
      chk("y_valid", y_valid, i == 14);
      chk("busy", busy, i <= NT + 3);
      chk("overrun", overrun, 0);
      if (i == drop_at) en = 1'b0;
    end
  endtask

  initial begin
`ifdef FIR_MAC_SEQ_OVERRUN_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    rst = 1'b1; en = 1'b1; rst_b = 1'b1; en_b = 1'b0;
    repeat (3) step();
    chk("rst_state", fsm_state, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_we", x_we, 0);
    chk("rst_waddr", x_waddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_mac_en", mac_en, 0);

    // Twelve samples: first tick after DIV-1 edges, then every 862 cycles.
    rst = 1'b0;
    wait_tick(n);
    chk("first_tick_wait", n, 861);
    run_seq(0, 0);
    for (int s = 1; s < 12; s++) begin
      wait_tick(n);
      chk("tick_period", n, 848);
      run_seq(s % 11, 0);
    end

    // Reset in the middle of MAC aborts the sequence.
    wait_tick(n);
    chk("tick_before_rst", n, 848);
    repeat (6) step();
    chk("pre_rst_state", fsm_state, 2);
    rst = 1'b1;
    step();
    chk("midrst_state", fsm_state, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_raddr", x_raddr, 0);
    chk("midrst_craddr", c_raddr, 0);
    chk("midrst_waddr", x_waddr, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (y_valid) n++;
    end
    chk("no_yv_after_abort", n, 0);
    wait_tick(n);
    chk("tick_after_rst", n, 847);
    run_seq(0, 0);

    // en dropped two cycles after the tick: sequence still completes.
    wait_tick(n);
    chk("tick_before_en_drop", n, 848);
    run_seq(1, 2);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (sample_tick) n++;
    end
    chk("no_tick_en_low", n, 0);
    en = 1'b1;
    wait_tick(n);
    chk("tick_after_en", n, 861);
    run_seq(2, 0);

    // DIV=10 instance: every second tick arrives while busy and is dropped.
    rst_b = 1'b0; en_b = 1'b1;
    repeat (9) step();
    chk("b_tick1", tick_b, 1);
    chk("b_busy1", busy_b, 0);
    step();
    chk("b_we1", x_we_b, 1);
    chk("b_waddr1", x_waddr_b, 0);
    repeat (9) step();
    chk("b_tick2", tick_b, 1);
    chk("b_busy2", busy_b, 1);
    chk("b_ovr_before", overrun_b, 0);
    step();
    chk("b_we_dropped", x_we_b, 0);
    chk("b_ovr2", overrun_b, exp_ovr);
    repeat (3) step();
    chk("b_yv1", y_valid_b, 1);
    repeat (6) step();
    chk("b_tick3", tick_b, 1);
    chk("b_busy3", busy_b, 0);
    step();
    chk("b_we3", x_we_b, 1);
    chk("b_waddr3", x_waddr_b, 1);
    chk("b_ovr3", overrun_b, exp_ovr);
    repeat (19) step();
    chk("b_tick5", tick_b, 1);
    step();
    chk("b_we5", x_we_b, 1);
    chk("b_waddr5", x_waddr_b, 2);
    chk("b_ovr5", overrun_b, exp_ovr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
